// File: rtl/dsp_file_reader.sv
// dsp_file_reader: pops one sample from a RAM-resident circular file.
// Reads the 0x20-byte descriptor at RAM_BASE + 0x20*file_num. Checks for
// empty/error, fetches the sample, writes STATUS and advances RD_PTR.
// Then it returns the sample on a one-cycle file_read_valid pulse.
// Optional build macro DSP_FILE_READER_CACHE_EN keeps START/END/CONTROL of the
// last file so that a repeat request skips those three descriptor reads.

`ifndef WB_RAM0
`define WB_RAM0 32'h0000_0000
`endif

module dsp_file_reader #(
  parameter int              dw       = 32,
  parameter int              aw       = 32,
  parameter logic [aw-1:0]   RAM_BASE = `WB_RAM0
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [7:0]    file_num,
  input  logic          file_read,
  output logic          busy,
  output logic [dw-1:0] file_read_data,
  output logic          file_read_valid,
  output logic          file_empty,
  output logic          file_error,
  output logic [aw-1:0] address,
  output logic          start,
  output logic [3:0]    selection,
  output logic          write,
  output logic [dw-1:0] data_wr,
  input  logic [dw-1:0] data_rd,
  input  logic          active
);

  localparam logic [aw-1:0] OFF_START   = aw'(8'h00);
  localparam logic [aw-1:0] OFF_END     = aw'(8'h04);
  localparam logic [aw-1:0] OFF_RD_PTR  = aw'(8'h08);
  localparam logic [aw-1:0] OFF_WR_PTR  = aw'(8'h0C);
  localparam logic [aw-1:0] OFF_STATUS  = aw'(8'h10);
  localparam logic [aw-1:0] OFF_CONTROL = aw'(8'h14);

  typedef enum logic [4:0] {
    IDLE,
    RD_START,   RD_START_DONE,
    RD_END,     RD_END_DONE,
    RD_RDPTR,   RD_RDPTR_DONE,
    RD_WRPTR,   RD_WRPTR_DONE,
    RD_STATUS,  RD_STATUS_DONE,
    RD_CONTROL, RD_CONTROL_DONE,
    CHECK,
    RD_DATA,    RD_DATA_DONE,
    WR_STATUS,  WR_STATUS_DONE,
    WR_RDPTR,   WR_RDPTR_DONE,
    RESPOND
  } state_t;

  state_t state, state_next;

  logic [7:0]    file_idx;
  logic [dw-1:0] start_ptr, end_ptr, rd_ptr, wr_ptr, status, sample;
  logic [1:0]    size_r;
  logic          empty_r, error_r;

  logic [aw-1:0] desc_base;
  logic [dw-1:0] inc, rd_inc, lane_data;
  logic [3:0]    data_sel;
  logic          wrap;

  assign desc_base = RAM_BASE + aw'({file_idx, 5'b00000});

  // Pointer increment and lane selection derived from size and pointer offset.
  always_comb begin
    inc       = '0;
    data_sel  = 4'hF;
    lane_data = '0;
    case (size_r)
      2'b00: begin
        inc       = dw'(4);
        data_sel  = 4'hF;
        lane_data = data_rd;
      end
      2'b01: begin
        inc       = dw'(2);
        data_sel  = rd_ptr[1] ? 4'hC : 4'h3;
        lane_data = dw'(rd_ptr[1] ? data_rd[31:16] : data_rd[15:0]);
      end
      2'b10: begin
        inc      = dw'(1);
        data_sel = 4'b0001 << rd_ptr[1:0];
        case (rd_ptr[1:0])
          2'd0:    lane_data = dw'(data_rd[7:0]);
          2'd1:    lane_data = dw'(data_rd[15:8]);
          2'd2:    lane_data = dw'(data_rd[23:16]);
          default: lane_data = dw'(data_rd[31:24]);
        endcase
      end
      default: ;
    endcase
  end

  assign rd_inc = rd_ptr + inc;
  assign wrap   = rd_inc > end_ptr;

`ifdef DSP_FILE_READER_CACHE_EN
  logic       cache_valid;
  logic [7:0] cache_num;
  logic       use_cache;
  logic       cache_hit;

  assign cache_hit = cache_valid && (cache_num == file_num);

  // Track which file's START/END/CONTROL are held and whether they can be reused.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cache_valid <= 1'b0;
      cache_num   <= '0;
      use_cache   <= 1'b0;
    end else if (state == IDLE && file_read) begin
      use_cache <= cache_hit;
    end else if (state == RESPOND) begin
      cache_valid <= !error_r;
      cache_num   <= file_idx;
    end
  end
`endif

  // State register.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and bus request outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_next = state;
    start      = 1'b0;
    write      = 1'b0;
    address    = '0;
    selection  = 4'h0;
    data_wr    = '0;
    case (state)
      IDLE: if (file_read) begin
`ifdef DSP_FILE_READER_CACHE_EN
        state_next = cache_hit ? RD_RDPTR : RD_START;
`else
        state_next = RD_START;
`endif
      end
      RD_START: begin
        start = 1'b1; selection = 4'hF; address = desc_base + OFF_START;
        if (active) state_next = RD_START_DONE;
      end
      RD_START_DONE: if (!active) state_next = RD_END;
      RD_END: begin
        start = 1'b1; selection = 4'hF; address = desc_base + OFF_END;
        if (active) state_next = RD_END_DONE;
      end
      RD_END_DONE: if (!active) state_next = RD_RDPTR;
      RD_RDPTR: begin
        start = 1'b1; selection = 4'hF; address = desc_base + OFF_RD_PTR;
        if (active) state_next = RD_RDPTR_DONE;
      end
      RD_RDPTR_DONE: if (!active) state_next = RD_WRPTR;
      RD_WRPTR: begin
        start = 1'b1; selection = 4'hF; address = desc_base + OFF_WR_PTR;
        if (active) state_next = RD_WRPTR_DONE;
      end
      RD_WRPTR_DONE: if (!active) state_next = RD_STATUS;
      RD_STATUS: begin
        start = 1'b1; selection = 4'hF; address = desc_base + OFF_STATUS;
        if (active) state_next = RD_STATUS_DONE;
      end
      RD_STATUS_DONE: if (!active) begin
`ifdef DSP_FILE_READER_CACHE_EN
        state_next = use_cache ? CHECK : RD_CONTROL;
`else
        state_next = RD_CONTROL;
`endif
      end
      RD_CONTROL: begin
        start = 1'b1; selection = 4'hF; address = desc_base + OFF_CONTROL;
        if (active) state_next = RD_CONTROL_DONE;
      end
      RD_CONTROL_DONE: if (!active) state_next = CHECK;
      CHECK: begin
        if (size_r == 2'b11 || rd_ptr == wr_ptr) state_next = WR_STATUS;
        else                                     state_next = RD_DATA;
      end
      RD_DATA: begin
        start = 1'b1; selection = data_sel;
        address = aw'({rd_ptr[dw-1:2], 2'b00});
        if (active) state_next = RD_DATA_DONE;
      end
      RD_DATA_DONE: if (!active) state_next = WR_STATUS;
      WR_STATUS: begin
        start = 1'b1; write = 1'b1; selection = 4'hF;
        address = desc_base + OFF_STATUS; data_wr = status;
        if (active) state_next = WR_STATUS_DONE;
      end
      WR_STATUS_DONE: if (!active) state_next = (empty_r || error_r) ? RESPOND : WR_RDPTR;
      WR_RDPTR: begin
        start = 1'b1; write = 1'b1; selection = 4'hF;
        address = desc_base + OFF_RD_PTR; data_wr = rd_ptr;
        if (active) state_next = WR_RDPTR_DONE;
      end
      WR_RDPTR_DONE: if (!active) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Descriptor capture, CHECK outcome, sample fetch and pointer advance.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    // NOTE: non-blocking throughout, so sample and pointer updates in one cycle both see the pre-edge rd_ptr.
    if (wb_rst) begin
      file_idx       <= '0;
      start_ptr      <= '0;
      end_ptr        <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      status         <= '0;
      size_r         <= '0;
      sample         <= '0;
      empty_r        <= 1'b0;
      error_r        <= 1'b0;
      file_read_data <= '0;
    end else begin
      case (state)
        IDLE: if (file_read) begin
          file_idx <= file_num;
          empty_r  <= 1'b0;
          error_r  <= 1'b0;
        end
        RD_START_DONE:   if (!active) start_ptr <= data_rd;
        RD_END_DONE:     if (!active) end_ptr   <= data_rd;
        RD_RDPTR_DONE:   if (!active) rd_ptr    <= data_rd;
        RD_WRPTR_DONE:   if (!active) wr_ptr    <= data_rd;
        RD_STATUS_DONE:  if (!active) status    <= data_rd;
        RD_CONTROL_DONE: if (!active) size_r    <= data_rd[1:0];
        CHECK: begin
          if (size_r == 2'b11) begin
            error_r   <= 1'b1;
            status[2] <= 1'b1;
          end else if (rd_ptr == wr_ptr) begin
            empty_r   <= 1'b1;
            status[1] <= 1'b1;
          end else begin
            status[1] <= 1'b0;
          end
        end
        RD_DATA_DONE: if (!active) begin
          sample <= lane_data;
          if (wrap) begin
            rd_ptr    <= start_ptr;
            status[0] <= 1'b1;
          end else begin
            rd_ptr <= rd_inc;
          end
        end
        default: ;
      endcase
      if (state != RESPOND && state_next == RESPOND)
        file_read_data <= (empty_r || error_r) ? '0 : sample;
    end
  end

  assign busy            = (state != IDLE);
  assign file_read_valid = (state == RESPOND);
  assign file_empty      = (state == RESPOND) && empty_r;
  assign file_error      = (state == RESPOND) && error_r;

endmodule

// File: tb/tb_dsp_file_reader.sv
// tb_dsp_file_reader: directed bench for dsp_file_reader with a scoreboard.
// A 1/1 bus responder serves a word RAM; requests push their expected
// response into a queue that a separate monitor pops on file_read_valid.

`timescale 1ns/1ps

module tb_dsp_file_reader;

  localparam logic [31:0] BASE = 32'h0000_0400;

`ifdef DSP_FILE_READER_CACHE_EN
  localparam int HIT_ACC = 6;
  localparam int HIT_LAT = 21;
`else
  localparam int HIT_ACC = 9;
  localparam int HIT_LAT = 30;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        empty;
    logic        error;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [7:0]  file_num;
  logic        file_read;
  logic        busy;
  logic [31:0] file_read_data;
  logic        file_read_valid;
  logic        file_empty;
  logic        file_error;
  logic [31:0] address;
  logic        start;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        active;

  logic [31:0] mem [0:2047];
  resp_t       exp_q[$];
  acc_t        acc_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_resp  = 0;
  int          n_exp   = 0;
  int          cyc     = 0;
  int          acc_cyc = 0;
  int          resp_cyc = 0;

  dsp_file_reader #(.dw(32), .aw(32), .RAM_BASE(BASE)) dut (
    .wb_clk          (wb_clk),
    .wb_rst          (wb_rst),
    .file_num        (file_num),
    .file_read       (file_read),
    .busy            (busy),
    .file_read_data  (file_read_data),
    .file_read_valid (file_read_valid),
    .file_empty      (file_empty),
    .file_error      (file_error),
    .address         (address),
    .start           (start),
    .selection       (selection),
    .write           (write),
    .data_wr         (data_wr),
    .data_rd         (data_rd),
    .active          (active)
  );

  always #5 wb_clk = ~wb_clk;

  initial forever begin
    @(posedge wb_clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the oldest expectation whenever the DUT responds.
  initial forever begin
    resp_t e;
    @(negedge wb_clk);
    if (file_read_valid) begin
      n_resp++;
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_response", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp_data",  file_read_data, e.data);
        check("resp_empty", file_empty,     e.empty);
        check("resp_error", file_error,     e.error);
      end
    end
  end

  // Bus responder: active rises one cycle after start and stays for one cycle.
  task automatic responder();
    forever begin
      @(posedge wb_clk or posedge wb_rst);
      if (wb_rst) begin
        active <= 1'b0;
      end else if (active) begin
        active <= 1'b0;
      end else if (start) begin
        active <= 1'b1;
        acc_q.push_back(acc_t'{address, selection, write, data_wr});
        if (write) mem[address[12:2]] <= data_wr;
        else       data_rd <= mem[address[12:2]];
      end
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[12:2]);
  endfunction

  task automatic set_desc(input logic [7:0] f, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] rd, input logic [31:0] wr,
                          input logic [31:0] st, input logic [31:0] ctl);
    logic [31:0] b;
    b = BASE + 32'(f) * 32'h20;
    mem[widx(b + 32'h00)] = s;
    mem[widx(b + 32'h04)] = e;
    mem[widx(b + 32'h08)] = rd;
    mem[widx(b + 32'h0C)] = wr;
    mem[widx(b + 32'h10)] = st;
    mem[widx(b + 32'h14)] = ctl;
  endtask

  function automatic logic [31:0] desc_word(input logic [7:0] f, input logic [31:0] off);
    return mem[widx(BASE + 32'(f) * 32'h20 + off)];
  endfunction

  function automatic int n_writes();
    int n;
    n = 0;
    foreach (acc_q[i]) if (acc_q[i].we) n++;
    return n;
  endfunction

  task automatic do_read(input logic [7:0] f, input bit expect_resp,
                         input logic [31:0] d, input logic em, input logic er);
    if (expect_resp) begin
      exp_q.push_back(resp_t'{d, em, er});
      n_exp++;
    end
    acc_q.delete();
    @(negedge wb_clk);
    file_num  = f;
    file_read = 1'b1;
    @(negedge wb_clk);
    file_read = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (n_resp < target && n < 200) begin
      @(negedge wb_clk);
      n++;
    end
    check("resp_arrived", 64'(n_resp >= target), 1);
  endtask

  // Latency counts both the acceptance cycle and the file_read_valid cycle.
  task automatic check_latency(input string name, input int lat);
    check(name, 64'(resp_cyc - acc_cyc + 2), 64'(lat));
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {busy, start, write, file_read_valid, file_empty, file_error, selection}, 0);
    check({name, "_bus"}, {address | data_wr, file_read_data}, 0);
  endtask

  initial begin
    wb_rst    = 1'b1;
    file_read = 1'b0;
    file_num  = '0;
    active    = 1'b0;
    data_rd   = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    fork responder(); join_none

    #1;
    check_outputs_zero("reset_outputs");
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;

    // Word read from the middle of the file; STATUS bit1 cleared, other bits kept.
    mem[widx(32'h1004)] = 32'hDEAD_BEEF;
    mem[widx(32'h1008)] = 32'hCAFE_F00D;
    mem[widx(32'h100C)] = 32'h1234_5678;
    mem[widx(32'h1000)] = 32'hAABB_CCDD;
    set_desc(8'd2, 32'h1000, 32'h100C, 32'h1004, 32'h100C, 32'h0000_00A2, 32'h0);
    do_read(8'd2, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    wait_resp(n_exp);
    check_latency("word_latency", 30);
    check("word_accesses", acc_q.size(), 9);
    check("word_data_addr", acc_q[6].addr, 32'h1004);
    check("word_rdptr", desc_word(8'd2, 32'h08), 32'h1008);
    check("word_status", desc_word(8'd2, 32'h10), 32'h0000_00A0);

    // Byte read from the top lane of a word.
    set_desc(8'd3, 32'h1000, 32'h100C, 32'h1003, 32'h1008, 32'h0, 32'h2);
    do_read(8'd3, 1'b1, 32'h0000_00AA, 1'b0, 1'b0);
    wait_resp(n_exp);
    check("byte_sel", acc_q[6].sel, 4'h8);
    check("byte_addr", acc_q[6].addr, 32'h1000);
    check("byte_rdptr", desc_word(8'd3, 32'h08), 32'h1004);

    // Halfword read from the upper half.
    set_desc(8'd6, 32'h1000, 32'h100C, 32'h1002, 32'h1000, 32'h0, 32'h1);
    do_read(8'd6, 1'b1, 32'h0000_AABB, 1'b0, 1'b0);
    wait_resp(n_exp);
    check("hword_sel", acc_q[6].sel, 4'hC);
    check("hword_rdptr", desc_word(8'd6, 32'h08), 32'h1004);

    // Read at END wraps RD_PTR to START and sets the sticky wrap bit.
    set_desc(8'd4, 32'h1000, 32'h100C, 32'h100C, 32'h1000, 32'h0000_0010, 32'h0);
    do_read(8'd4, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    wait_resp(n_exp);
    check("wrap_rdptr", desc_word(8'd4, 32'h08), 32'h1000);
    check("wrap_status", desc_word(8'd4, 32'h10), 32'h0000_0011);

    // Empty file: only the STATUS write, RD_PTR untouched.
    set_desc(8'd5, 32'h1000, 32'h100C, 32'h1008, 32'h1008, 32'h0000_0001, 32'h0);
    do_read(8'd5, 1'b1, 32'h0, 1'b1, 1'b0);
    wait_resp(n_exp);
    check("empty_accesses", acc_q.size(), 7);
    check("empty_writes", n_writes(), 1);
    check("empty_status", desc_word(8'd5, 32'h10), 32'h0000_0003);
    check("empty_rdptr", desc_word(8'd5, 32'h08), 32'h1008);

    // Undefined size: error, no data access; a pulse while busy is dropped.
    set_desc(8'd7, 32'h1000, 32'h100C, 32'h1000, 32'h1008, 32'h0, 32'h3);
    do_read(8'd7, 1'b1, 32'h0, 1'b0, 1'b1);
    repeat (4) @(negedge wb_clk);
    file_num  = 8'd2;
    file_read = 1'b1;
    @(negedge wb_clk);
    file_read = 1'b0;
    wait_resp(n_exp);
    check("error_accesses", acc_q.size(), 7);
    check("error_status", desc_word(8'd7, 32'h10), 32'h0000_0004);
    check("error_rdptr", desc_word(8'd7, 32'h08), 32'h1000);
    repeat (40) @(negedge wb_clk);
    check("dropped_pulse_resp_count", n_resp, n_exp);
    check("dropped_pulse_accesses", acc_q.size(), 7);

    // Two back-to-back reads of the same file.
    set_desc(8'd2, 32'h1000, 32'h100C, 32'h1004, 32'h1000, 32'h0, 32'h0);
    do_read(8'd2, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    wait_resp(n_exp);
    check("b2b_first_accesses", acc_q.size(), 9);
    check_latency("b2b_first_latency", 30);
    do_read(8'd2, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    wait_resp(n_exp);
    check("b2b_second_accesses", acc_q.size(), 64'(HIT_ACC));
    check_latency("b2b_second_latency", HIT_LAT);
    check("b2b_rdptr", desc_word(8'd2, 32'h08), 32'h100C);

    // Reset mid-request: outputs clear without a clock edge, next request is full.
    do_read(8'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (9) @(negedge wb_clk);
    check("abort_busy_before_reset", busy, 1'b1);
    wb_rst = 1'b1;
    #1;
    check_outputs_zero("async_reset_outputs");
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    do_read(8'd2, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    wait_resp(n_exp);
    check("post_reset_accesses", acc_q.size(), 9);
    check_latency("post_reset_latency", 30);
    check("post_reset_rdptr", desc_word(8'd2, 32'h08), 32'h1000);
    check("post_reset_status", desc_word(8'd2, 32'h10), 32'h0000_0001);

    repeat (5) @(negedge wb_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
